// File: rtl/clk_div_ctrl_if.sv
// Config handshake bundle for clk_div_ctrl: the register/config side is the
// master offering new half-periods, the controller is the slave.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_half, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_half, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for an even-ratio clock divider.
// Glitch-free start/stop of clk_out, new half-periods accepted over a
// valid/ready handshake and applied only at the high->low period boundary.
// Optional macro CLK_DIV_CTRL_PERIOD_CNT_EN adds a 32-bit wrapping count of
// clk_out rising edges on output period_cnt.
module clk_div_ctrl #(
  parameter int          CNT_W    = 16,
  parameter int unsigned DEF_HALF = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  output logic [31:0]      period_cnt,
`endif
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_cfg_err;
  logic             r_cfg_ready;
  logic             r_running;
  logic [CNT_W-1:0] r_cur_half;
  logic [CNT_W-1:0] r_pend_half;

  logic       w_accept;
  logic       w_cfg_zero;
  logic       w_term;
  logic       w_active;
  logic       w_rise;
  logic       w_fall;
  logic       w_stop_idle;
  logic       w_boundary;
  logic       w_to_idle;
  logic [1:0] w_state_nxt;

  // Period-boundary decode and next-state selection
  always_comb begin
    w_accept    = cfg.cfg_valid && r_cfg_ready;
    w_cfg_zero  = (cfg.cfg_half == '0);
    w_term      = (r_count == (r_cur_half - CNT_W'(1)));
    w_active    = (r_state != S_IDLE);
    w_rise      = w_active && w_term && !r_clk_out;
    w_fall      = w_active && w_term && r_clk_out;
    // STOP leaves for IDLE either immediately from the low phase or on the
    // terminal high->low toggle, so no short high pulse is ever produced.
    w_stop_idle = (r_state == S_STOP) && !en && (!r_clk_out || w_term);
    w_boundary  = w_fall || w_stop_idle;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = en ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = en ? S_RUN : S_STOP;
      S_STOP:  w_state_nxt = en ? S_RUN : (w_stop_idle ? S_IDLE : S_STOP);
      default: w_state_nxt = S_IDLE;
    endcase
    w_to_idle = (w_state_nxt == S_IDLE);
  end

  // State, divider counter, output clock and config registers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_running   <= 1'b0;
      r_cur_half  <= CNT_W'(DEF_HALF);
      r_pend_half <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= !w_to_idle;
      r_tick    <= w_rise;
      r_cfg_err <= w_accept && w_cfg_zero;

      if (!w_active || w_to_idle) begin
        r_count   <= '0;
        r_clk_out <= 1'b0;
      end else if (w_term) begin
        r_count   <= '0;
        r_clk_out <= ~r_clk_out;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end

      // A pending value exists only while cfg_ready is low, and a new one is
      // accepted only while it is high, so these two updates never collide.
      if (w_boundary && !r_cfg_ready) begin
        r_cur_half  <= r_pend_half;
        r_cfg_ready <= 1'b1;
      end
      if (w_accept && !w_cfg_zero) begin
        if (!w_active || w_to_idle) begin
          r_cur_half <= cfg.cfg_half;
        end else begin
          r_pend_half <= cfg.cfg_half;
          r_cfg_ready <= 1'b0;
        end
      end
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [31:0] r_period_cnt;

  // Free-running count of clk_out rising edges, cleared only by reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (w_rise) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign clk_out       = r_clk_out;
  assign tick          = r_tick;
  assign running       = r_running;
  assign cur_half      = r_cur_half;
  assign cfg.cfg_ready = r_cfg_ready;
  assign cfg.cfg_err   = r_cfg_err;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the even-ratio clock divider function. It sequences start and stop of the divided clock glitch-free, and accepts new divide ratios over a valid/ready handshake. New ratios are applied only at a period boundary. It sits between the register/config logic and the divided-clock consumers, all in the clk_in domain.

Parameters:
CNT_W, 16, width of half-period counter and cfg_half field
DEF_HALF, 5, half-period (clk_in cycles) loaded at reset; divide ratio = 2*half; must be >= 1

Ports:
clk_in     input   1      source clock; all logic on posedge
rst_n      input   1      synchronous reset, active low
en         input   1      run request: 1 = produce clk_out, 0 = stop at low phase
cfg_valid  input   1      new half-period offered
cfg_half   input   CNT_W  requested half-period, valid with cfg_valid
cfg_ready  output  1      controller can accept a config
cfg_err    output  1      1-cycle pulse: accepted cfg_half was 0, discarded
clk_out    output  1      divided clock, registered, 50% duty
tick       output  1      1-cycle pulse, registered, high in the cycle clk_out first reads 1
running    output  1      1 in RUN or STOP state
cur_half   output  CNT_W  half-period currently in use

Behaviour:
- Reset (rst_n=0 at posedge) values:
  - clk_out=0, tick=0, cfg_err=0, cfg_ready=1, running=0.
  - cur_half=DEF_HALF, count=0, state=IDLE.
  - Any pending config is dropped. Reset mid-operation aborts immediately; a truncated clk_out high pulse is accepted only in this case.
- States: IDLE, RUN, STOP.
- IDLE:
  - clk_out=0, count=0.
  - en=1 -> RUN on the next edge; count starts at 0.
- RUN:
  - Each cycle: if count==cur_half-1, then count<=0 and clk_out<=~clk_out; else count<=count+1.
  - High phase and low phase are each exactly cur_half cycles. The first rise occurs cur_half cycles after RUN entry.
  - tick=1 on the same edge clk_out goes 0->1.
  - en=0 -> STOP.
- STOP:
  - If clk_out=0: go to IDLE next edge, count<=0. The low phase may be truncated; there is never a short high pulse.
  - If clk_out=1: keep counting until the terminal toggle 1->0, then go to IDLE on that same edge.
  - en=1 while in STOP -> return to RUN, counting undisturbed.
- Config handshake:
  - Transfer occurs when cfg_valid&&cfg_ready at a posedge.
  - cfg_half==0: cfg_err=1 for one cycle; nothing stored; cfg_ready stays 1.
  - In IDLE: cur_half<=cfg_half on the accepting edge. If en is also 1 on that edge, RUN starts with the new value.
  - In RUN/STOP: value goes to a pending register; cfg_ready<=0.
  - The pending value is applied on the edge where clk_out toggles 1->0 (count<=0, cur_half<=pending). The next low phase uses the new value; cfg_ready<=1 on the same edge.
  - If STOP reaches IDLE with clk_out already 0, the pending value is applied on IDLE entry.
  - Only one pending value at a time; cfg_valid is held off by cfg_ready=0.
- Width rules:
  - count is CNT_W bits unsigned.
  - Terminal compare is count==cur_half-1, CNT_W-bit.
  - cur_half=1 gives divide-by-2. The maximum is 2^CNT_W-1.
- running = (state!=IDLE), registered.

Optional Feature:
CLK_DIV_CTRL_PERIOD_CNT_EN
- Defined: adds output period_cnt[31:0], reset to 0, incremented on every tick, wrapping from 0xFFFFFFFF to 0. It is not cleared by en or config changes.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, en=1 held, DEF_HALF=5 -> clk_out toggles every 5 clk_in cycles (period 10). tick is 1 cycle wide, once per 10 cycles. First rise 5 cycles after RUN entry.
- While running at half=5, send cfg_half=2 mid-high phase -> cfg_ready drops. Remaining high phase stays 5 cycles. At the 1->0 edge cur_half=2 and cfg_ready=1. Subsequent phases are 2 cycles each.
- en=0 during high phase (count=1, half=5) -> clk_out stays high 3 more cycles, falls, running=0, clk_out held 0. en=0 during low phase -> IDLE next edge, no high pulse.
- In IDLE send cfg_half=0 -> cfg_err pulses 1 cycle, cur_half unchanged (5), cfg_ready stays 1. Then cfg_half=1 with en=1 on the same edge -> divide-by-2 from start.
- rst_n=0 asserted while clk_out=1 with a pending config -> next cycle clk_out=0, cur_half=5, cfg_ready=1, running=0, and the pending value is never applied.
- With CLK_DIV_CTRL_PERIOD_CNT_EN and half=1: run 20 cycles -> period_cnt=10. Force period_cnt near wrap (0xFFFFFFFF) -> wraps to 0 on next tick.
